reg_fwd_scoreboard: RTL and testbench
=====================================

# reg_fwd_scoreboard

Parametrised register-read forwarding and hazard unit for the ID stage. It serves NUM_RD read ports and forwards from EX, MEM and, optionally, WB. A per-register pending-write scoreboard tracks long-latency writers such as mul/div and load-miss, and stalls any read that targets a register still pending. A saturating stall-cycle counter is included for performance monitoring.

## Interface
- NUM_RD, 2: number of read ports (1..4)
- AW, 5: register address width
- DW, 32: data width
- PW, 2: pending-counter width per register; maximum outstanding writes per register is 2^PW-1
- SCW, 16: stall-cycle counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AW  port i address at bits [i*AW +: AW]
- rf_data  in  NUM_RD*DW  register-file read data, per port
- ex_we, ex_waddr, ex_wdata, ex_load  in  1/AW/DW/1  EX-stage writer; ex_load=1 means ex_wdata is not valid yet
- mem_we, mem_waddr, mem_wdata  in  1/AW/DW  MEM-stage writer
- wb_we, wb_waddr, wb_wdata  in  1/AW/DW  WB-stage writer; the same cycle's register-file write
- ll_issue, ll_issue_addr  in  1/AW  long-latency op issued that will write ll_issue_addr
- ll_done, ll_done_addr  in  1/AW  long-latency result written to the register file this cycle
- ll_issue_ready  out  1  0 when the ll_issue_addr counter is at maximum
- rd_data  out  NUM_RD*DW  forwarded operand, per port
- rd_stall  out  NUM_RD  per-port hazard
- stall  out  1  OR of rd_stall
- stall_cnt  out  SCW  saturating count of cycles with stall=1
- stall_cnt_clr  in  1  synchronous clear of stall_cnt

## Operation
- Per-port data mux, combinational. Priority order:
  - rd_en=0 → data 0
  - addr 0 → data 0
  - EX match (ex_we & addr==ex_waddr) → ex_wdata
  - MEM match → mem_wdata
  - WB match → wb_wdata (only when RRP_WB_BYPASS_EN is defined)
  - otherwise rf_data
- rd_stall[i] is 1 when rd_en[i] and addr≠0 and any of the following holds:
  - EX match with ex_load=1
  - pend[addr]≠0
  - WB match, when RRP_WB_BYPASS_EN is not defined
- Address 0 never stalls and is never tracked.
- Scoreboard is a PW-bit counter pend[r] for r = 1..2^AW-1:
  - ll_issue & ll_issue_ready & addr≠0 → +1
  - ll_done & addr≠0 & pend≠0 → −1
  - issue and done to the same register in the same cycle → no change
  - ll_done with pend=0 is ignored; no wrap below 0
- ll_issue_ready = (ll_issue_addr==0) | (pend[ll_issue_addr] ≠ 2^PW-1). An issue while not ready is dropped; the pipeline must hold it.
- stall_cnt:
  - +1 per cycle with stall=1
  - saturates at 2^SCW-1
  - stall_cnt_clr has priority over increment and yields 0

## Timing
- Reset (rst_n=0, asynchronous) sets all pend to 0 and stall_cnt to 0.
- Combinational outputs during reset:
  - rd_stall=0 for all ports (pend is cleared)
  - ex_load matches still stall
  - rd_data follows the mux
- Forwarding and stall: 0-cycle latency, combinational from the inputs.
- pend updates take effect at the next rising edge:
  - a read in the same cycle as ll_issue to its register does not stall
  - a read in the cycle after ll_issue does stall
- ll_done in cycle N: the read in cycle N still stalls; the cycle N+1 read is unstalled and takes rf_data.
- Reset mid-operation discards all pending state; the pipeline flush is the owner's responsibility.

## Configuration
- RRP_WB_BYPASS_EN defined: WB is the third forwarding source and a WB match never stalls.
- RRP_WB_BYPASS_EN undefined: no WB source; a WB match stalls one cycle, for a read-before-write register file.

## Test plan
- Priority: port0 addr 3, ex_we/ex_waddr 3/ex_wdata 0xAAAA, mem 3/0xBBBB, rf 0xCCCC → 0xAAAA. Drop ex_we → 0xBBBB. Drop mem_we → 0xCCCC (bypass off) or the WB value (bypass on).
- Load-use: ex_load=1, ex_waddr 5, port1 reads 5 → rd_stall=2'b10, stall=1. Same stimulus with addr 0 → no stall, data 0.
- Scoreboard: ll_issue r7 in cycle 0.
  - Cycle 0 read r7 → no stall.
  - Cycles 1..k stall.
  - ll_done r7 in cycle k → the cycle k+1 read returns rf_data, no stall.
- Saturation: PW=2, three issues to r4 → ll_issue_ready=0. A fourth issue is dropped. A same-cycle issue+done keeps pend=3. Three dones → pend=0. A spurious done stays at 0.
- stall_cnt:
  - hold stall for 2^SCW+5 cycles → 0xFFFF
  - clr together with stall → 0
  - asynchronous reset mid-run → pend and count 0 immediately
- Bypass macro: WB match on r9 with wb_wdata 0x1234 → bypass on gives 0x1234 with no stall; bypass off gives rd_stall=1.

Source files
------------

// File: rtl/reg_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_fwd_scoreboard
//
// ID-stage register-read forwarding and hazard unit. Each of NUM_RD read
// ports selects its operand from EX, MEM, optionally WB, or the register
// file. A per-register pending-write counter tracks long-latency writers
// (mul/div, load-miss) and stalls reads of registers still in flight.
// A saturating counter accumulates stall cycles for performance monitoring.
//
// Build option:
//   RRP_WB_BYPASS_EN  defined   -> WB is a forwarding source, WB match never stalls
//                     undefined -> no WB source, WB match stalls one cycle
//                                  (read-before-write register file)
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_rd_en/i_rd_addr/i_rf_data  per-port read request and register-file data
//   i_ex_*                       EX-stage writer (i_ex_load: data not ready yet)
//   i_mem_*                      MEM-stage writer
//   i_wb_*                       WB-stage writer (same-cycle register-file write)
//   i_ll_issue/i_ll_issue_addr   long-latency op issued, will write that register
//   i_ll_done/i_ll_done_addr     long-latency result written this cycle
//   o_ll_issue_ready             issue target counter is not full
//   o_rd_data/o_rd_stall         per-port forwarded operand and hazard flag
//   o_stall                      OR of all port hazards
//   o_stall_cnt/i_stall_cnt_clr  saturating stall-cycle counter and its clear
// ---------------------------------------------------------------------------
module reg_fwd_scoreboard #(
    parameter int NUM_RD = 2,
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int PW     = 2,
    parameter int SCW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD-1:0]    i_rd_en,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    input  logic [NUM_RD*DW-1:0] i_rf_data,
    input  logic                 i_ex_we,
    input  logic [AW-1:0]        i_ex_waddr,
    input  logic [DW-1:0]        i_ex_wdata,
    input  logic                 i_ex_load,
    input  logic                 i_mem_we,
    input  logic [AW-1:0]        i_mem_waddr,
    input  logic [DW-1:0]        i_mem_wdata,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_waddr,
    input  logic [DW-1:0]        i_wb_wdata,
    input  logic                 i_ll_issue,
    input  logic [AW-1:0]        i_ll_issue_addr,
    input  logic                 i_ll_done,
    input  logic [AW-1:0]        i_ll_done_addr,
    output logic                 o_ll_issue_ready,
    output logic [NUM_RD*DW-1:0] o_rd_data,
    output logic [NUM_RD-1:0]    o_rd_stall,
    output logic                 o_stall,
    output logic [SCW-1:0]       o_stall_cnt,
    input  logic                 i_stall_cnt_clr
);

    localparam int            NREG     = 1 << AW;
    localparam logic [PW-1:0] PEND_MAX = '1;
    localparam logic [SCW-1:0] CNT_MAX = '1;

    logic [PW-1:0]  r_pend [NREG];
    logic [SCW-1:0] r_stall_cnt;

    logic w_issue_ready;
    logic w_same;
    logic w_issue_ok;
    logic w_done_ok;
    logic w_stall;

    // ---------------------------------------------------------------------
    // Pending-write scoreboard
    // ---------------------------------------------------------------------
    assign w_issue_ready = (i_ll_issue_addr == '0) |
                           (r_pend[i_ll_issue_addr] != PEND_MAX);

    // Issue and done to the same register cancel out, even when the issue
    // itself would have been refused because the counter is full.
    assign w_same     = i_ll_issue & i_ll_done & (i_ll_issue_addr == i_ll_done_addr);
    assign w_issue_ok = i_ll_issue & w_issue_ready & (i_ll_issue_addr != '0) & ~w_same;
    assign w_done_ok  = i_ll_done & (i_ll_done_addr != '0) &
                        (r_pend[i_ll_done_addr] != '0) & ~w_same;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_issue_ok && (i_ll_issue_addr == AW'(r))) begin
                    r_pend[r] <= r_pend[r] + PW'(1);
                end else if (w_done_ok && (i_ll_done_addr == AW'(r))) begin
                    r_pend[r] <= r_pend[r] - PW'(1);
                end
            end
        end
    end

    assign o_ll_issue_ready = w_issue_ready;

    // ---------------------------------------------------------------------
    // Per-port forwarding mux and hazard detection
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        logic [AW-1:0] w_addr;
        logic          w_act;
        logic          w_ex_hit;
        logic          w_mem_hit;
        logic          w_wb_hit;
        logic          w_pend_hit;
        logic [DW-1:0] w_data;

        assign w_addr     = i_rd_addr[g*AW +: AW];
        assign w_act      = i_rd_en[g] & (w_addr != '0);
        assign w_ex_hit   = i_ex_we & (w_addr == i_ex_waddr);
        assign w_mem_hit  = i_mem_we & (w_addr == i_mem_waddr);
        assign w_wb_hit   = i_wb_we & (w_addr == i_wb_waddr);
        assign w_pend_hit = (r_pend[w_addr] != '0);

        always_comb begin
            w_data = '0;
            if (w_act) begin
                if (w_ex_hit) begin
                    w_data = i_ex_wdata;
                end else if (w_mem_hit) begin
                    w_data = i_mem_wdata;
`ifdef RRP_WB_BYPASS_EN
                end else if (w_wb_hit) begin
                    w_data = i_wb_wdata;
`endif
                end else begin
                    w_data = i_rf_data[g*DW +: DW];
                end
            end
        end

        assign o_rd_data[g*DW +: DW] = w_data;

`ifdef RRP_WB_BYPASS_EN
        assign o_rd_stall[g] = w_act & ((w_ex_hit & i_ex_load) | w_pend_hit);
`else
        // Register file is read before it is written, so a WB match must
        // wait one cycle for the write to land.
        assign o_rd_stall[g] = w_act & ((w_ex_hit & i_ex_load) | w_pend_hit | w_wb_hit);
`endif
    end

`ifndef RRP_WB_BYPASS_EN
    logic w_unused_wb_wdata;
    assign w_unused_wb_wdata = ^i_wb_wdata;
`endif

    assign w_stall = |o_rd_stall;
    assign o_stall = w_stall;

    // ---------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + SCW'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_reg_fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_fwd_scoreboard
//
// Directed stimulus pushes hand-computed expectations, tagged with the
// cycle they belong to, into a queue. A monitor on the falling edge pops
// and compares every expectation due in that cycle.
// ---------------------------------------------------------------------------
module tb_reg_fwd_scoreboard;

    localparam int NR  = 2;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int PW  = 2;
    localparam int SCW = 16;

    localparam int K_D0  = 0;
    localparam int K_D1  = 1;
    localparam int K_RS  = 2;
    localparam int K_ST  = 3;
    localparam int K_RDY = 4;
    localparam int K_CNT = 5;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rf_data;
    logic              ex_we;
    logic [AW-1:0]     ex_waddr;
    logic [DW-1:0]     ex_wdata;
    logic              ex_load;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              wb_we;
    logic [AW-1:0]     wb_waddr;
    logic [DW-1:0]     wb_wdata;
    logic              ll_issue;
    logic [AW-1:0]     ll_issue_addr;
    logic              ll_done;
    logic [AW-1:0]     ll_done_addr;
    logic              ll_issue_ready;
    logic [NR*DW-1:0]  o_rd_data;
    logic [NR-1:0]     o_rd_stall;
    logic              o_stall;
    logic [SCW-1:0]    o_stall_cnt;
    logic              stall_cnt_clr;

    reg_fwd_scoreboard #(
        .NUM_RD(NR), .AW(AW), .DW(DW), .PW(PW), .SCW(SCW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_rd_en          (rd_en),
        .i_rd_addr        (rd_addr),
        .i_rf_data        (rf_data),
        .i_ex_we          (ex_we),
        .i_ex_waddr       (ex_waddr),
        .i_ex_wdata       (ex_wdata),
        .i_ex_load        (ex_load),
        .i_mem_we         (mem_we),
        .i_mem_waddr      (mem_waddr),
        .i_mem_wdata      (mem_wdata),
        .i_wb_we          (wb_we),
        .i_wb_waddr       (wb_waddr),
        .i_wb_wdata       (wb_wdata),
        .i_ll_issue       (ll_issue),
        .i_ll_issue_addr  (ll_issue_addr),
        .i_ll_done        (ll_done),
        .i_ll_done_addr   (ll_done_addr),
        .o_ll_issue_ready (ll_issue_ready),
        .o_rd_data        (o_rd_data),
        .o_rd_stall       (o_rd_stall),
        .o_stall          (o_stall),
        .o_stall_cnt      (o_stall_cnt),
        .i_stall_cnt_clr  (stall_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] actual(int kind);
        case (kind)
            K_D0:    return 64'(o_rd_data[DW-1:0]);
            K_D1:    return 64'(o_rd_data[2*DW-1:DW]);
            K_RS:    return 64'(o_rd_stall);
            K_ST:    return 64'(o_stall);
            K_RDY:   return 64'(ll_issue_ready);
            default: return 64'(o_stall_cnt);
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    exp_t        m_e;
    logic [63:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e   = q.pop_front();
            m_act = actual(m_e.kind);
            checks++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                errors++;
                $display("FAIL %s cycle %0d actual %0h expected %0h",
                         m_e.name, m_e.cyc, m_act, m_e.val);
            end
        end
    end

    task automatic expect_v(int kind, logic [63:0] v, string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; rf_data = '0;
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_load = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        ll_issue = 1'b0; ll_issue_addr = '0;
        ll_done = 1'b0; ll_done_addr = '0;
        stall_cnt_clr = 1'b0;
    endtask

    task automatic rd(int p, logic en, logic [AW-1:0] a, logic [DW-1:0] rf);
        rd_en[p]            = en;
        rd_addr[p*AW +: AW] = a;
        rf_data[p*DW +: DW] = rf;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();

        // Reset state
        expect_v(K_CNT, 64'h0, "rst_cnt");
        expect_v(K_ST,  64'h0, "rst_stall");
        expect_v(K_RDY, 64'h1, "rst_ready");
        step();
        // ex_load match still stalls while in reset
        ex_we = 1'b1; ex_load = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h5;
        rd(1, 1'b1, 5'd5, 32'h0);
        expect_v(K_RS, 64'h2, "rst_load_stall");
        step();
        clear_inputs();
        rst_n = 1'b1;

        // Forwarding priority
        step();
        rd(0, 1'b1, 5'd3, 32'hCCCC);
        rd(1, 1'b0, 5'd3, 32'h1111);
        ex_we  = 1'b1; ex_waddr  = 5'd3; ex_wdata  = 32'hAAAA;
        mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hBBBB;
        wb_we  = 1'b1; wb_waddr  = 5'd3; wb_wdata  = 32'hDDDD;
        expect_v(K_D0, 64'hAAAA, "prio_ex");
        expect_v(K_D1, 64'h0, "disabled_port");
        step();
        ex_we = 1'b0;
        expect_v(K_D0, 64'hBBBB, "prio_mem");
        step();
        mem_we = 1'b0;
`ifdef RRP_WB_BYPASS_EN
        expect_v(K_D0, 64'hDDDD, "prio_wb");
        expect_v(K_RS, 64'h0, "prio_wb_stall");
`else
        expect_v(K_D0, 64'hCCCC, "prio_rf");
        expect_v(K_RS, 64'h1, "prio_wb_stall");
`endif

        // Load-use hazard
        step();
        clear_inputs();
        ex_we = 1'b1; ex_load = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h55;
        rd(1, 1'b1, 5'd5, 32'h1234_0000);
        expect_v(K_RS, 64'h2, "load_use_rs");
        expect_v(K_ST, 64'h1, "load_use_stall");
        step();
        ex_waddr = 5'd0;
        rd(1, 1'b1, 5'd0, 32'h1234_0000);
        expect_v(K_RS, 64'h0, "addr0_rs");
        expect_v(K_D1, 64'h0, "addr0_data");

        // Scoreboard: issue r7, done after k=3 cycles
        step();
        clear_inputs();
        ll_issue = 1'b1; ll_issue_addr = 5'd7;
        rd(0, 1'b1, 5'd7, 32'h77);
        expect_v(K_RS, 64'h0, "sb_same_cycle");
        expect_v(K_D0, 64'h77, "sb_same_data");
        for (int k = 1; k <= 3; k++) begin
            step();
            ll_issue = 1'b0;
            rd(1, 1'b1, 5'd8, 32'h88);
            if (k == 3) begin
                ll_done = 1'b1; ll_done_addr = 5'd7;
            end
            expect_v(K_RS, 64'h1, "sb_pending");
        end
        step();
        ll_done = 1'b0;
        expect_v(K_RS, 64'h0, "sb_release");
        expect_v(K_D0, 64'h77, "sb_release_data");

        // Saturation on r4 (PW=2 -> max 3)
        step();
        clear_inputs();
        ll_issue = 1'b1; ll_issue_addr = 5'd4;
        expect_v(K_RDY, 64'h1, "sat_rdy0");
        step();
        step();
        expect_v(K_RDY, 64'h1, "sat_rdy2");
        step();
        expect_v(K_RDY, 64'h0, "sat_full");
        step();
        ll_done = 1'b1; ll_done_addr = 5'd4;
        expect_v(K_RDY, 64'h0, "sat_drop");
        step();
        ll_issue = 1'b0;
        rd(0, 1'b1, 5'd4, 32'h44);
        expect_v(K_RDY, 64'h0, "sat_same_cycle");
        expect_v(K_RS, 64'h1, "sat_stall3");
        step();
        expect_v(K_RDY, 64'h1, "sat_pend2");
        step();
        expect_v(K_RS, 64'h1, "sat_pend1");
        step();
        expect_v(K_RS, 64'h0, "sat_pend0");
        step();
        ll_done = 1'b0;
        expect_v(K_RS, 64'h0, "sat_spurious_rs");
        expect_v(K_RDY, 64'h1, "sat_spurious_rdy");

        // Stall counter saturation
        step();
        clear_inputs();
        stall_cnt_clr = 1'b1;
        step();
        stall_cnt_clr = 1'b0;
        ex_we = 1'b1; ex_load = 1'b1; ex_waddr = 5'd5;
        rd(0, 1'b1, 5'd5, 32'h0);
        expect_v(K_CNT, 64'h0, "cnt_start");
        step();
        expect_v(K_CNT, 64'h1, "cnt_one");
        repeat (65540) step();
        expect_v(K_CNT, 64'hFFFF, "cnt_sat");
        step();
        stall_cnt_clr = 1'b1;
        step();
        stall_cnt_clr = 1'b0;
        expect_v(K_CNT, 64'h0, "cnt_clr");
        step();
        expect_v(K_CNT, 64'h1, "cnt_after_clr");
        step();
        ex_we = 1'b0; ex_load = 1'b0;
        ll_issue = 1'b1; ll_issue_addr = 5'd7;
        rd(0, 1'b1, 5'd7, 32'h0);
        expect_v(K_RS, 64'h0, "cnt_issue_rs");
        expect_v(K_CNT, 64'h2, "cnt_two");
        step();
        ll_issue = 1'b0;
        expect_v(K_ST, 64'h1, "arst_pre_stall");
        expect_v(K_CNT, 64'h2, "cnt_hold");
        step();
        rst_n = 1'b0;
        expect_v(K_CNT, 64'h0, "arst_cnt");
        expect_v(K_RS, 64'h0, "arst_pend");
        step();
        step();
        rst_n = 1'b1;
        step();
        expect_v(K_RS, 64'h0, "post_rst_rs");
        expect_v(K_CNT, 64'h0, "post_rst_cnt");

        // WB bypass on r9
        step();
        clear_inputs();
        wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h1234;
        rd(0, 1'b1, 5'd9, 32'h5555);
`ifdef RRP_WB_BYPASS_EN
        expect_v(K_D0, 64'h1234, "wb_bypass_data");
        expect_v(K_RS, 64'h0, "wb_bypass_rs");
`else
        expect_v(K_RS, 64'h1, "wb_nobypass_rs");
        expect_v(K_ST, 64'h1, "wb_nobypass_stall");
`endif

        step();
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
